disaster_behavioral: RTL and testbench
======================================

DISASTER_BEHAVIORAL -- requirements
Module: disaster_behavioral

Interface
- REQ-001: Parameters: none; every width in this block is fixed.
- REQ-002: clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: rst, input, 1 bit: asynchronous, active-high reset.
- REQ-004: r1,r0, input, 1 bit each: rain level R={r1,r0}, 0..3.
- REQ-005: s1,s0, input, 1 bit each: seismic level S={s1,s0}, 0..3.
- REQ-006: w1,w0, input, 1 bit each: wind level W={w1,w0}, 0..3.
- REQ-007: l1,l0, input, 1 bit each: water/sea level L={l1,l0}, 0..3.
- REQ-008: mode, input, 1 bit: 0 = priority (single alert), 1 = multi (all alerts).
- REQ-009: flood_led, output, 1 bit: flood alert.
- REQ-010: cyclone_led, output, 1 bit: cyclone alert.
- REQ-011: earthquake_led, output, 1 bit: earthquake alert.
- REQ-012: tsunami_led, output, 1 bit: tsunami alert.
- REQ-013: active_count, output, 3 bits: number of LEDs currently asserted, 0..4.

Function
- REQ-014: Raw flood condition SHALL be R>=2 AND L>=2.
- REQ-015: Raw cyclone condition SHALL be W==3 AND R>=1.
- REQ-016: Raw earthquake condition SHALL be S>=2.
- REQ-017: Raw tsunami condition SHALL be S>=2 AND L==3.
- REQ-018: Each level SHALL be treated as a 2-bit unsigned value; no other encoding exists.
- REQ-019: In mode 1, each LED SHALL equal its own raw condition, independent of the others.
- REQ-020: In mode 0, at most one LED SHALL be asserted, chosen by the fixed priority flood > cyclone > earthquake > tsunami.
- REQ-021: In mode 0 with no raw condition true, all LEDs SHALL be 0.
- REQ-022: Inputs and mode SHALL be sampled on each rising clk edge.
- REQ-023: LEDs and active_count SHALL be registered, with exactly one cycle of latency from sampled inputs.
- REQ-024: active_count SHALL equal the population count of the four registered LEDs in the same cycle.
- REQ-025: A mode change SHALL take effect on the next registered output, with no glitch cycle.

Reset
- REQ-026: While rst=1, all four LEDs and active_count SHALL be 0 immediately, without waiting for a clock edge.
- REQ-027: The first rising edge after rst deasserts SHALL load outputs from the inputs sampled at that edge.
- REQ-028: A reset applied mid-operation SHALL discard the pending result; no stale alert reappears after release.

Structure
- REQ-029: A shared package SHALL hold the level thresholds (flood R/L = 2; cyclone W = 3, R = 1; quake S = 2; tsunami L = 3) and the mode encodings.
- REQ-030: The raw-condition plus mode-select logic SHALL be a combinational sub-module named disaster_classifier, followed by a register stage in disaster_behavioral.
- REQ-031: Functionally identical variants disaster_gate (gate primitives) and disaster_dataflow (continuous assigns) SHALL exist with the identical port list and timing.
- REQ-032: All three variants SHALL produce identical outputs for every input.

Verification
- REQ-033: rst=1 with all inputs 3 -> all LEDs 0 and active_count 0 while reset is held.
- REQ-034: mode=1, R=S=W=L=3, one clock -> all four LEDs 1 and active_count=4.
- REQ-035: mode=0, R=S=W=L=3, one clock -> flood_led only, active_count=1.
- REQ-036: mode=0, R=0, S=3, W=3, L=3 -> earthquake_led only; mode=1 with the same levels -> earthquake and tsunami LEDs, active_count=2.
- REQ-037: Sweep all 512 {mode,R,S,W,L} combinations against a reference model -> exact match one cycle later, with all three variants agreeing.
- REQ-038: Assert rst between two vectors -> outputs clear asynchronously, and the post-release output reflects only the new inputs.

Source files
------------

// File: rtl/disaster_pkg.sv
// Shared thresholds, mode encodings and alert bundle for the disaster alert block.
package disaster_pkg;

   localparam logic [1:0] FLOOD_R_MIN   = 2'd2;
   localparam logic [1:0] FLOOD_L_MIN   = 2'd2;
   localparam logic [1:0] CYCLONE_W     = 2'd3;
   localparam logic [1:0] CYCLONE_R_MIN = 2'd1;
   localparam logic [1:0] QUAKE_S_MIN   = 2'd2;
   localparam logic [1:0] TSUNAMI_L     = 2'd3;

   typedef enum logic {
      MODE_PRIORITY = 1'b0,
      MODE_MULTI    = 1'b1
   } mode_e;

   typedef struct packed {
      logic flood;
      logic cyclone;
      logic quake;
      logic tsunami;
   } alert_t;

   function automatic logic [2:0] popcount4(input alert_t a);
      popcount4 = 3'(a.flood) + 3'(a.cyclone) + 3'(a.quake) + 3'(a.tsunami);
   endfunction

endpackage

// File: rtl/disaster_classifier.sv
// Combinational raw-condition detection and mode-dependent alert selection.
module disaster_classifier
   import disaster_pkg::*;
(
   input  logic [1:0] r,
   input  logic [1:0] s,
   input  logic [1:0] w,
   input  logic [1:0] l,
   input  logic       mode,
   output alert_t     alerts
);

   alert_t raw;

   // raw hazard conditions from the four 2-bit levels
   always_comb begin
      raw.flood   = (r >= FLOOD_R_MIN) && (l >= FLOOD_L_MIN);
      raw.cyclone = (w == CYCLONE_W) && (r >= CYCLONE_R_MIN);
      raw.quake   = (s >= QUAKE_S_MIN);
      raw.tsunami = (s >= QUAKE_S_MIN) && (l == TSUNAMI_L);
   end

   // priority mode keeps only the most severe alert: flood > cyclone > quake > tsunami
   always_comb begin
      alerts = '0;
      case (mode_e'(mode))
         MODE_MULTI: alerts = raw;
         MODE_PRIORITY: begin
            if (raw.flood)        alerts.flood   = 1'b1;
            else if (raw.cyclone) alerts.cyclone = 1'b1;
            else if (raw.quake)   alerts.quake   = 1'b1;
            else if (raw.tsunami) alerts.tsunami = 1'b1;
            else                  alerts         = '0;
         end
         default: alerts = '0;
      endcase
   end

endmodule

// File: rtl/disaster_dataflow.sv
// Continuous-assignment variant of the disaster alert unit, same ports and timing.
module disaster_dataflow
   import disaster_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       r1,
   input  logic       r0,
   input  logic       s1,
   input  logic       s0,
   input  logic       w1,
   input  logic       w0,
   input  logic       l1,
   input  logic       l0,
   input  logic       mode,
   output logic       flood_led,
   output logic       cyclone_led,
   output logic       earthquake_led,
   output logic       tsunami_led,
   output logic [2:0] active_count
);

   alert_t raw;
   alert_t nxt;
   alert_t leds;

   assign raw.flood   = ({r1, r0} >= FLOOD_R_MIN) && ({l1, l0} >= FLOOD_L_MIN);
   assign raw.cyclone = ({w1, w0} == CYCLONE_W) && ({r1, r0} >= CYCLONE_R_MIN);
   assign raw.quake   = ({s1, s0} >= QUAKE_S_MIN);
   assign raw.tsunami = ({s1, s0} >= QUAKE_S_MIN) && ({l1, l0} == TSUNAMI_L);

   assign nxt.flood   = raw.flood;
   assign nxt.cyclone = raw.cyclone & (mode | ~raw.flood);
   assign nxt.quake   = raw.quake   & (mode | ~(raw.flood | raw.cyclone));
   assign nxt.tsunami = raw.tsunami & (mode | ~(raw.flood | raw.cyclone | raw.quake));

   // output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         leds         <= '0;
         active_count <= 3'd0;
      end else begin
         leds         <= nxt;
         active_count <= popcount4(nxt);
      end
   end

   assign flood_led      = leds.flood;
   assign cyclone_led    = leds.cyclone;
   assign earthquake_led = leds.quake;
   assign tsunami_led    = leds.tsunami;

endmodule

// File: rtl/disaster_gate.sv
// Gate-primitive variant of the disaster alert unit; thresholds reduce to single bits.
module disaster_gate (
   input  logic       clk,
   input  logic       rst,
   input  logic       r1,
   input  logic       r0,
   input  logic       s1,
   input  logic       s0,
   input  logic       w1,
   input  logic       w0,
   input  logic       l1,
   input  logic       l0,
   input  logic       mode,
   output logic       flood_led,
   output logic       cyclone_led,
   output logic       earthquake_led,
   output logic       tsunami_led,
   output logic [2:0] active_count
);

   logic flood, r_any, cyc, tsu, nf, nc, nq, nfc, nfcq;
   logic c_en, q_en, t_en, c_n, q_n, t_n;
   logic s_ab, c_ab, s_abc, c_abc1, c_abc2, c_abc, s_all, c_d, cnt1, cnt2;

   // R>=2 is r1, L>=2 is l1, S>=2 is s1; s0 never matters
   and g_flood (flood, r1, l1);
   or  g_rany  (r_any, r1, r0);
   and g_cyc   (cyc, w1, w0, r_any);
   and g_tsu   (tsu, s1, l1, l0);
   not g_nf    (nf, flood);
   not g_nc    (nc, cyc);
   not g_nq    (nq, s1);
   and g_nfc   (nfc, nf, nc);
   and g_nfcq  (nfcq, nfc, nq);
   or  g_cen   (c_en, mode, nf);
   or  g_qen   (q_en, mode, nfc);
   or  g_ten   (t_en, mode, nfcq);
   and g_cn    (c_n, cyc, c_en);
   and g_qn    (q_n, s1, q_en);
   and g_tn    (t_n, tsu, t_en);

   // population count: full adder on three bits, then add the fourth
   xor g_sab   (s_ab, flood, c_n);
   and g_cab   (c_ab, flood, c_n);
   xor g_sabc  (s_abc, s_ab, q_n);
   and g_cabc1 (c_abc1, s_ab, q_n);
   or  g_cabc  (c_abc, c_ab, c_abc1);
   xor g_sall  (s_all, s_abc, t_n);
   and g_cd    (c_d, s_abc, t_n);
   xor g_cnt1  (cnt1, c_abc, c_d);
   and g_cnt2  (cnt2, c_abc, c_d);
   assign c_abc2 = c_abc;

   // output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flood_led      <= 1'b0;
         cyclone_led    <= 1'b0;
         earthquake_led <= 1'b0;
         tsunami_led    <= 1'b0;
         active_count   <= 3'd0;
      end else begin
         flood_led      <= flood;
         cyclone_led    <= c_n;
         earthquake_led <= q_n;
         tsunami_led    <= t_n;
         active_count   <= {cnt2, cnt1, s_all};
      end
   end

   logic unused_bits;
   assign unused_bits = s0 ^ c_abc2;

endmodule

// File: rtl/disaster_behavioral.sv
// Behavioural disaster alert unit: classifier followed by one register stage.
module disaster_behavioral
   import disaster_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       r1,
   input  logic       r0,
   input  logic       s1,
   input  logic       s0,
   input  logic       w1,
   input  logic       w0,
   input  logic       l1,
   input  logic       l0,
   input  logic       mode,
   output logic       flood_led,
   output logic       cyclone_led,
   output logic       earthquake_led,
   output logic       tsunami_led,
   output logic [2:0] active_count
);

   alert_t next_alerts;
   alert_t leds;

   disaster_classifier u_classifier (
      .r      ({r1, r0}),
      .s      ({s1, s0}),
      .w      ({w1, w0}),
      .l      ({l1, l0}),
      .mode   (mode),
      .alerts (next_alerts)
   );

   // count is taken from the same next value so it always matches the LEDs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         leds         <= '0;
         active_count <= 3'd0;
      end else begin
         leds         <= next_alerts;
         active_count <= popcount4(next_alerts);
      end
   end

   assign flood_led      = leds.flood;
   assign cyclone_led    = leds.cyclone;
   assign earthquake_led = leds.quake;
   assign tsunami_led    = leds.tsunami;

endmodule

// File: tb/tb_disaster_behavioral.sv
// Scoreboard bench for disaster_behavioral, cross-checked against the gate and dataflow variants.
module tb_disaster_behavioral;

   typedef struct packed {
      logic [3:0] leds;
      logic [2:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic r1 = 1'b1, r0 = 1'b1, s1 = 1'b1, s0 = 1'b1;
   logic w1 = 1'b1, w0 = 1'b1, l1 = 1'b1, l0 = 1'b1, mode = 1'b1;
   logic [3:0] leds [3];
   logic [2:0] cnt  [3];
   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   disaster_behavioral u_beh (.clk(clk), .rst(rst), .r1(r1), .r0(r0), .s1(s1), .s0(s0),
      .w1(w1), .w0(w0), .l1(l1), .l0(l0), .mode(mode),
      .flood_led(leds[0][3]), .cyclone_led(leds[0][2]), .earthquake_led(leds[0][1]),
      .tsunami_led(leds[0][0]), .active_count(cnt[0]));
   disaster_gate u_gate (.clk(clk), .rst(rst), .r1(r1), .r0(r0), .s1(s1), .s0(s0),
      .w1(w1), .w0(w0), .l1(l1), .l0(l0), .mode(mode),
      .flood_led(leds[1][3]), .cyclone_led(leds[1][2]), .earthquake_led(leds[1][1]),
      .tsunami_led(leds[1][0]), .active_count(cnt[1]));
   disaster_dataflow u_df (.clk(clk), .rst(rst), .r1(r1), .r0(r0), .s1(s1), .s0(s0),
      .w1(w1), .w0(w0), .l1(l1), .l0(l0), .mode(mode),
      .flood_led(leds[2][3]), .cyclone_led(leds[2][2]), .earthquake_led(leds[2][1]),
      .tsunami_led(leds[2][0]), .active_count(cnt[2]));

   // reference model written from the hazard rules; v = {mode,R,S,W,L}
   function automatic exp_t model(input logic [8:0] v);
      logic [1:0] rr, ss, ww, ll;
      logic f, c, q, t;
      exp_t e;
      rr = v[7:6]; ss = v[5:4]; ww = v[3:2]; ll = v[1:0];
      f = (rr >= 2'd2) && (ll >= 2'd2);
      c = (ww == 2'd3) && (rr >= 2'd1);
      q = (ss >= 2'd2);
      t = (ss >= 2'd2) && (ll == 2'd3);
      if (v[8]) e.leds = {f, c, q, t};
      else if (f) e.leds = 4'b1000;
      else if (c) e.leds = 4'b0100;
      else if (q) e.leds = 4'b0010;
      else if (t) e.leds = 4'b0001;
      else e.leds = 4'b0000;
      e.cnt = 3'(e.leds[3]) + 3'(e.leds[2]) + 3'(e.leds[1]) + 3'(e.leds[0]);
      return e;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input exp_t e);
      string tag [3] = '{"beh", "gate", "df"};
      for (int k = 0; k < 3; k++) begin
         check({name, "_", tag[k], "_leds"}, int'(leds[k]), int'(e.leds));
         check({name, "_", tag[k], "_cnt"}, int'(cnt[k]), int'(e.cnt));
      end
   endtask

   task automatic drive(input logic [8:0] v);
      {mode, r1, r0, s1, s0, w1, w0, l1, l0} = v;
   endtask

   task automatic issue(input logic [8:0] v, input exp_t e);
      @(negedge clk);
      drive(v);
      sb.push_back(e);
   endtask

   // monitor: the result of the vector sampled at this edge is due now
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst && sb.size() > 0) begin
         e = sb.pop_front();
         check_all("vec", e);
      end
   end

   initial begin
      exp_t zero;
      zero = '0;
      #1 rst = 1'b1;
      #1 check_all("rst_async", zero);
      repeat (2) @(posedge clk);
      #2 check_all("rst_held", zero);
      @(negedge clk);
      rst = 1'b0;

      issue(9'b1_11_11_11_11, '{leds: 4'b1111, cnt: 3'd4});
      issue(9'b0_11_11_11_11, '{leds: 4'b1000, cnt: 3'd1});
      issue(9'b0_00_11_11_11, '{leds: 4'b0010, cnt: 3'd1});
      issue(9'b1_00_11_11_11, '{leds: 4'b0011, cnt: 3'd2});
      issue(9'b0_01_00_11_00, '{leds: 4'b0100, cnt: 3'd1});
      issue(9'b1_10_00_00_10, '{leds: 4'b1000, cnt: 3'd1});
      issue(9'b1_01_00_10_10, '{leds: 4'b0000, cnt: 3'd0});
      issue(9'b0_00_00_00_00, '{leds: 4'b0000, cnt: 3'd0});
      issue(9'b1_01_10_11_11, '{leds: 4'b0111, cnt: 3'd3});

      for (int i = 0; i < 512; i++) issue(9'(i), model(9'(i)));

      // mid-operation reset: the pending vector must never surface
      issue(9'b1_11_11_11_11, '{leds: 4'b1111, cnt: 3'd4});
      @(negedge clk);
      drive(9'b0_11_00_00_11);
      #2 rst = 1'b1;
      sb.delete();
      #1 check_all("rst_mid_async", zero);
      @(posedge clk);
      #2 check_all("rst_mid_held", zero);
      rst = 1'b0;
      issue(9'b0_01_00_11_00, '{leds: 4'b0100, cnt: 3'd1});
      repeat (2) @(negedge clk);

      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
